gaussian_correlator: RTL and testbench

- Downstream consumer of the Gaussian generator's per-cycle pair G1/G2 (IEEE-754 single precision).
- Converts the pair to signed fixed point and applies the Heston correlation: Z1 = G1, Z2 = rho*G1 + rho_bar*G2, with rho_bar = sqrt(1-rho^2) precomputed by software.
- Output goes to the path-update stage through a valid/ready handshake.
- Samples arriving while the pipeline is stalled are dropped and counted.

---
 rtl/gaussian_pkg.sv | 23 ++
 rtl/gaussian_correlator_fp32_to_fixed.sv | 58 +++++
 rtl/gaussian_correlator.sv | 124 ++++++++++++
 tb/tb_gaussian_correlator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
// Shared constants for the Gaussian correlator: default widths,
// FP32 field positions and the symmetric saturation limits.
package gaussian_pkg;

    localparam int INT_W_DEF  = 4;
    localparam int FRAC_W_DEF = 20;
    localparam int RHO_W_DEF  = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int W_DEF      = INT_W_DEF + FRAC_W_DEF;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    // Symmetric limits: -max is -(2^(W-1)-1), never the bare sign pattern
    localparam logic [W_DEF-1:0] SAT_POS = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic [W_DEF-1:0] SAT_NEG = {1'b1, {(W_DEF-2){1'b0}}, 1'b1};

endpackage

// File: rtl/gaussian_correlator_fp32_to_fixed.sv
// Combinational FP32 -> signed Q(INT_W).(FRAC_W) with half-up rounding.
// Ports: x (FP32 in), y (fixed out), sat (Inf/NaN/overflow flag).
module fp32_to_fixed
    import gaussian_pkg::*;
#(
    parameter int INT_W  = INT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic [31:0]                    x,
    output logic signed [INT_W+FRAC_W-1:0] y,
    output logic                           sat
);

    localparam int W = INT_W + FRAC_W;
    localparam logic [W-1:0] POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [7:0] E_SAT = 8'(EXP_BIAS + INT_W - 1);
    // Right shift that leaves one extra fraction bit for rounding
    localparam logic [7:0] SH0 = 8'(EXP_BIAS + MAN_W - 1 - FRAC_W);

    logic           sgn;
    logic [7:0]     e;
    logic [MAN_W-1:0] m;
    logic [MAN_W:0]   half;
    logic [MAN_W+1:0] sum;
    logic [W-1:0]   mag;
    logic           is_zero;
    logic           is_nan;
    logic           is_big;

    assign sgn  = x[SIGN_BIT];
    assign e    = x[EXP_HI:EXP_LO];
    assign m    = x[MAN_W-1:0];
    assign half = {1'b1, m} >> (SH0 - e);
    assign sum  = {1'b0, half} + (MAN_W+2)'(1);
    assign mag  = W'(sum >> 1);

    assign is_zero = (e == 8'd0);
    assign is_nan  = (e == EXP_SPECIAL) && (m != '0);
    // Rounding up to 2^(INT_W-1) also overflows
    assign is_big  = (e == EXP_SPECIAL) ? (m == '0)
                   : (!is_zero && ((e >= E_SAT) || (mag > POS)));

    always_comb begin
        y   = '0;
        sat = 1'b0;
        unique case (1'b1)
            is_zero: y = '0;
            is_nan:  sat = 1'b1;
            is_big: begin
                sat = 1'b1;
                y   = sgn ? NEG : POS;
            end
            default: y = sgn ? -mag : mag;
        endcase
    end

endmodule

// File: rtl/gaussian_correlator.sv
// Converts G1/G2 to fixed point and forms Z1=G1, Z2=rho*G1+rho_bar*G2.
// Ports: in_valid/in_ready/G1/G2 in, cfg_load/rho/rho_bar, out_* handshake, drop_cnt.
module gaussian_correlator
    import gaussian_pkg::*;
#(
    parameter int INT_W  = INT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int RHO_W  = RHO_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             G1,
    input  logic [31:0]             G2,
    input  logic                    cfg_load,
    input  logic signed [RHO_W-1:0] rho,
    input  logic signed [RHO_W-1:0] rho_bar,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INT_W+FRAC_W-1:0] Z1,
    output logic [INT_W+FRAC_W-1:0] Z2,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int W   = INT_W + FRAC_W;
    localparam int P_W = W + RHO_W;
    localparam int Q_W = P_W + 1;

    localparam logic signed [Q_W-1:0] RND =
        {{(Q_W-RHO_W+1){1'b0}}, 1'b1, {(RHO_W-2){1'b0}}};
    localparam logic signed [Q_W-1:0] POS_Q =
        {{(Q_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [Q_W-1:0] NEG_Q = -POS_Q;
    localparam logic [W-1:0] POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG = {1'b1, {(W-2){1'b0}}, 1'b1};

    logic                    stall;
    logic signed [W-1:0]     c1, c2;
    logic                    cs1, cs2;
    logic signed [RHO_W-1:0] rho_reg, rho_bar_reg;

    logic                    v1, sat_s1;
    logic signed [W-1:0]     g1_s1, g2_s1;
    logic                    v2, sat_s2;
    logic signed [W-1:0]     z1_s2;
    logic signed [P_W-1:0]   p1_s2, p2_s2;

    logic signed [Q_W-1:0]   sum_s3, q_s3;
    logic [W-1:0]            z2_next;
    logic                    sat_sum;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    fp32_to_fixed #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_cvt1 (
        .x(G1), .y(c1), .sat(cs1)
    );

    fp32_to_fixed #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_cvt2 (
        .x(G2), .y(c2), .sat(cs2)
    );

    assign sum_s3 = Q_W'(p1_s2) + Q_W'(p2_s2) + RND;
    assign q_s3   = sum_s3 >>> (RHO_W - 1);

    always_comb begin
        sat_sum = 1'b0;
        z2_next = W'(q_s3);
        if (q_s3 > POS_Q) begin
            sat_sum = 1'b1;
            z2_next = POS;
        end else if (q_s3 < NEG_Q) begin
            sat_sum = 1'b1;
            z2_next = NEG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rho_reg     <= '0;
            rho_bar_reg <= '0;
            drop_cnt    <= '0;
            v1          <= 1'b0;
            g1_s1       <= '0;
            g2_s1       <= '0;
            sat_s1      <= 1'b0;
            v2          <= 1'b0;
            z1_s2       <= '0;
            p1_s2       <= '0;
            p2_s2       <= '0;
            sat_s2      <= 1'b0;
            out_valid   <= 1'b0;
            Z1          <= '0;
            Z2          <= '0;
            out_sat     <= 1'b0;
        end else begin
            if (cfg_load) begin
                rho_reg     <= rho;
                rho_bar_reg <= rho_bar;
            end
            if (in_valid && stall && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_W'(1);
            if (!stall) begin
                v1        <= in_valid;
                g1_s1     <= c1;
                g2_s1     <= c2;
                sat_s1    <= cs1 | cs2;
                v2        <= v1;
                z1_s2     <= g1_s1;
                p1_s2     <= P_W'(rho_reg) * P_W'(g1_s1);
                p2_s2     <= P_W'(rho_bar_reg) * P_W'(g2_s1);
                sat_s2    <= sat_s1;
                out_valid <= v2;
                Z1        <= z1_s2;
                Z2        <= z2_next;
                out_sat   <= sat_s2 | sat_sum;
            end
        end
    end

endmodule

// File: tb/tb_gaussian_correlator.sv
// Directed bench for gaussian_correlator: conversion, correlation,
// saturation, backpressure/drops, config timing and mid-stream reset.
module tb_gaussian_correlator;
    import gaussian_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cfg_load;
    logic        out_valid, out_ready, out_sat;
    logic [31:0] g1, g2;
    logic [15:0] rho, rho_bar, drop_cnt;
    logic [23:0] z1, z2;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    gaussian_correlator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .G1(g1), .G2(g2),
        .cfg_load(cfg_load), .rho(rho), .rho_bar(rho_bar),
        .out_valid(out_valid), .out_ready(out_ready),
        .Z1(z1), .Z2(z2), .out_sat(out_sat),
        .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [15:0] r, input logic [15:0] rb);
        rho      = r;
        rho_bar  = rb;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic one(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [23:0] e1,
                       input logic [23:0] e2, input logic es);
        g1       = a;
        g2       = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check({tag, ".pre"}, 32'(out_valid), 32'd0);
        step();
        check({tag, ".v"}, 32'(out_valid), 32'd1);
        check({tag, ".z1"}, 32'(z1), 32'(e1));
        check({tag, ".z2"}, 32'(z2), 32'(e2));
        check({tag, ".sat"}, 32'(out_sat), 32'(es));
    endtask

    logic [31:0] bp_in [10] = '{
        32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
        32'h40200000, 32'h40400000, 32'h40600000, 32'h40800000,
        32'h40900000, 32'h40A00000
    };
    logic [23:0] bp_out [6] = '{
        24'h080000, 24'h100000, 24'h180000,
        24'h200000, 24'h280000, 24'h500000
    };

    initial begin
        int idx;
        rst       = 1'b1;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        out_ready = 1'b1;
        g1        = '0;
        g2        = '0;
        rho       = '0;
        rho_bar   = '0;
        step();
        step();
        rst = 1'b0;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.z1", 32'(z1), 32'd0);
        check("rst.z2", 32'(z2), 32'd0);
        check("rst.sat", 32'(out_sat), 32'd0);
        check("rst.drop", 32'(drop_cnt), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);

        cfg(16'h4000, 16'h6EDA);
        one("basic", 32'h3F800000, 32'hBF000000, 24'h100000, 24'h011260, 1'b0);
        cfg(16'h0000, 16'h7FFF);
        one("ident", 32'h40000000, 32'h3E800000, 24'h200000, 24'h03FFF8, 1'b0);

        cfg(16'h4000, 16'h6EDA);
        one("pos8", 32'h41000000, 32'h0, SAT_POS, 24'h400000, 1'b1);
        one("ninf", 32'hFF800000, 32'h0, SAT_NEG, 24'hC00001, 1'b1);
        one("nan", 32'h7FC00000, 32'h0, 24'h0, 24'h0, 1'b1);
        one("denorm", 32'h00000001, 32'h0, 24'h0, 24'h0, 1'b0);

        cfg(16'h0000, 16'h0000);
        one("half", 32'h35000000, 32'h0, 24'h000001, 24'h0, 1'b0);
        one("quarter", 32'h34800000, 32'h0, 24'h0, 24'h0, 1'b0);
        one("rnd_ovf", 32'h40FFFFFF, 32'h0, SAT_POS, 24'h0, 1'b1);

        cfg(16'h7FFF, 16'h7FFF);
        one("s3_pos", 32'h40F00000, 32'h40F00000, 24'h780000, SAT_POS, 1'b1);
        one("s3_neg", 32'hC0F00000, 32'hC0F00000, 24'h880000, SAT_NEG, 1'b1);

        // Backpressure: out_ready low for cycles 5..8
        cfg(16'h0000, 16'h0000);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid  = (c < 10);
            g1        = (c < 10) ? bp_in[c] : 32'h0;
            g2        = 32'h0;
            out_ready = !(c >= 5 && c <= 8);
            #1;
            if (c < 10)
                check("bp.in_ready", 32'(in_ready),
                      (c >= 5 && c <= 8) ? 32'd0 : 32'd1);
            if (c >= 5 && c <= 8) begin
                check("bp.hold_v", 32'(out_valid), 32'd1);
                check("bp.hold_z1", 32'(z1), 32'h180000);
            end
            if (out_valid && out_ready) begin
                if (idx < 6)
                    check("bp.order", 32'(z1), 32'(bp_out[idx]));
                else
                    check("bp.extra", 32'(idx), 32'd5);
                idx++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp.count", 32'(idx), 32'd6);
        check("bp.drops", 32'(drop_cnt), 32'd4);

        // Config switch on cycle 4 of a continuous stream
        cfg(16'h4000, 16'h6EDA);
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 8);
            g1       = 32'h3F800000;
            g2       = 32'h0;
            cfg_load = (c == 4);
            if (c == 4)
                rho = 16'hC000;
            #1;
            if (c >= 3) begin
                check("cfg.v", 32'(out_valid), 32'd1);
                check("cfg.z2", 32'(z2),
                      (c - 3 < 4) ? 32'h080000 : 32'hF80000);
            end
            step();
        end
        cfg_load = 1'b0;
        in_valid = 1'b0;
        step();
        step();

        // Reset with three samples in flight
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 3);
            g1       = (c == 1) ? 32'hFF800000 : 32'h3F800000;
            g2       = 32'h0;
            rst      = (c == 3);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mrst.valid", 32'(out_valid), 32'd0);
        check("mrst.z1", 32'(z1), 32'd0);
        check("mrst.z2", 32'(z2), 32'd0);
        check("mrst.sat", 32'(out_sat), 32'd0);
        check("mrst.drop", 32'(drop_cnt), 32'd0);
        check("mrst.in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            step();
            check("mrst.stale", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
